// File: rtl/descr_pkg.sv
// Shared constants, state encoding and single-step LFSR helper for the PRBS7 nibble descrambler.
package descr_pkg;

  localparam int LFSR_W = 7;
  localparam int TAP_HI = 6;
  localparam int TAP_LO = 5;

  typedef enum logic [0:0] {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  // Shift left, feeding back the XOR of the two top taps into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/keystream4.sv
// Combinational four-step PRBS7 unroll: k[i] is the output bit after i steps, s_next the state after four.
module keystream4
  import descr_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  output logic [3:0]        k,
  output logic [LFSR_W-1:0] s_next
);

  logic [LFSR_W-1:0] w_st;

  always_comb begin
    w_st = s;
    k    = '0;
    for (int i = 0; i < 4; i++) begin
      k[i] = w_st[TAP_HI];
      w_st = lfsr_step(w_st);
    end
    s_next = w_st;
  end

endmodule

// File: rtl/nibble_descrambler.sv
// Additive PRBS7 descrambler, one registered output stage: accept at edge N, data valid after edge N.
// in_ready drops while unseeded, during seed_load, or when the held output is not being drained.
module nibble_descrambler
  import descr_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_data,
  output logic                 seed_err,
  output logic [CNT_W-1:0]     nib_count
);

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic                r_out_vld;
  logic [3:0]          r_out_dat;
  logic                r_seed_err;
  logic [CNT_W-1:0]    r_nib_cnt;

  logic [3:0]          w_key;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic                w_in_rdy;
  logic                w_accept;
  logic                w_seed_ok;

  keystream4 u_keystream4 (
    .s      (r_lfsr),
    .k      (w_key),
    .s_next (w_lfsr_nxt)
  );

  assign w_in_rdy  = (r_state == ST_RUN) && !seed_load && (!r_out_vld || out_ready);
  assign w_accept  = in_valid && w_in_rdy;
  assign w_seed_ok = (seed != '0);

  // A zero seed would lock the LFSR at zero, so it is flagged and otherwise ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_UNSEEDED;
      r_lfsr     <= '0;
      r_seed_err <= 1'b0;
      r_nib_cnt  <= '0;
    end else if (seed_load) begin
      if (w_seed_ok) begin
        r_state    <= ST_RUN;
        r_lfsr     <= seed;
        r_seed_err <= 1'b0;
        r_nib_cnt  <= '0;
      end else begin
        r_seed_err <= 1'b1;
      end
    end else if (w_accept) begin
      r_lfsr    <= w_lfsr_nxt;
      r_nib_cnt <= r_nib_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= 4'h0;
    end else if (w_accept) begin
      r_out_vld <= 1'b1;
      r_out_dat <= in_data ^ w_key;
    end else if (out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign seed_err  = r_seed_err;
  assign nib_count = r_nib_cnt;

endmodule
